// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the decode/execute issue controller.
// Contents: pipeline widths, opcode constants, the issue FSM state type,
// the held-instruction record and opcode classification helpers.
package pipe_ctrl_pkg;

  localparam int NREG   = 16;
  localparam int RA_W   = 4;
  localparam int OP_W   = 5;
  localparam int IMM_W  = 32;
  localparam int SCNT_W = 16;

  typedef logic [OP_W-1:0] op_t;
  typedef logic [RA_W-1:0] reg_t;

  localparam op_t OP_NOP = 5'b00000;
  localparam op_t OP_LDI = 5'b11001;
  localparam op_t OP_ST  = 5'b11011;

  typedef enum logic [1:0] {EMPTY, HELD, STALL} state_e;

  typedef struct packed {
    op_t              opcode;
    reg_t             dest;
    reg_t             s1;
    reg_t             s2;
    logic [IMM_W-1:0] imm;
  } instr_t;

  // Opcodes that write their dest register.
  function automatic logic is_wr(input op_t op);
    case (op) inside
      [5'b00001:5'b00110], [5'b01000:5'b01011],
      5'b11000, 5'b11001, 5'b11010, 5'b11100, 5'b11110: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

  // Opcodes that read s1 and s2: every writer except load-immediate, plus store.
  function automatic logic reads_src(input op_t op);
    return (is_wr(op) && (op != OP_LDI)) || (op == OP_ST);
  endfunction

  // Store reads dest as its data register.
  function automatic logic reads_dest(input op_t op);
    return op == OP_ST;
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Ports: set_en_i/set_idx_i mark a register busy when a writer issues,
//        clr_en_i/clr_idx_i clear it on writeback (set wins on collision),
//        rd_idx_i[2:0] -> rd_busy_o[2:0] three hazard lookups,
//        busy_map_o the registered scoreboard.
// Macro ISSUE_BYPASS_EN: when defined, the lookups see this cycle's
// writeback clear; otherwise they see the registered map only.
module issue_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en_i,
  input  logic [RA_W-1:0]      set_idx_i,
  input  logic                 clr_en_i,
  input  logic [RA_W-1:0]      clr_idx_i,
  input  logic [2:0][RA_W-1:0] rd_idx_i,
  output logic [2:0]           rd_busy_o,
  output logic [NREG-1:0]      busy_map_o
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] set_mask, clr_mask, view;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en_i) set_mask[set_idx_i] = 1'b1;
    if (clr_en_i) clr_mask[clr_idx_i] = 1'b1;
    // Clearing a non-busy bit is harmless; set is applied last so it wins.
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

`ifdef ISSUE_BYPASS_EN
  assign view = busy_q & ~clr_mask;
`else
  assign view = busy_q;
`endif

  always_comb begin
    for (int i = 0; i < 3; i++) rd_busy_o[i] = view[rd_idx_i[i]];
  end

  // NOTE: the busy bits are real state that must start clean, so they sit on the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_map_o = busy_q;

endmodule

// File: rtl/decode_issue_ctrl.sv
// Issue controller between decode and execute. Holds one decoded
// instruction, stalls it while any register it reads (or writes) has a
// pending write in the scoreboard, and hands it to execute over
// out_valid/out_ready. Capture is zero-bubble: a new instruction is taken
// in the same cycle the held one issues.
// Ports: in_valid/in_ready + opcode_in/dest_in/s1_in/s2_in/imm_in from decode;
//        out_valid/out_ready + *_out to execute; wb_valid/wb_dest retire writes;
//        flush drops the held instruction; busy_map and stall_cnt observe state.
// Macro ISSUE_BYPASS_EN (in issue_scoreboard): writeback clear visible to
// the hazard check in the same cycle.
module decode_issue_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   opcode_in,
  input  logic [RA_W-1:0]   dest_in,
  input  logic [RA_W-1:0]   s1_in,
  input  logic [RA_W-1:0]   s2_in,
  input  logic [IMM_W-1:0]  imm_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   opcode_out,
  output logic [RA_W-1:0]   dest_out,
  output logic [RA_W-1:0]   s1_out,
  output logic [RA_W-1:0]   s2_out,
  output logic [IMM_W-1:0]  imm_out,
  input  logic              wb_valid,
  input  logic [RA_W-1:0]   wb_dest,
  output logic [NREG-1:0]   busy_map,
  output logic [SCNT_W-1:0] stall_cnt
);

  state_e              state_q, state_d;
  instr_t              held_q, held_d;
  logic [SCNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [2:0][RA_W-1:0] rd_idx;
  logic [2:0]          rd_busy;
  logic                occupied, hazard, issue, capture;

  // Lookups: 0 = s1, 1 = s2, 2 = dest.
  assign rd_idx = {held_q.dest, held_q.s2, held_q.s1};

  issue_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en_i   (issue && is_wr(held_q.opcode)),
    .set_idx_i  (held_q.dest),
    .clr_en_i   (wb_valid),
    .clr_idx_i  (wb_dest),
    .rd_idx_i   (rd_idx),
    .rd_busy_o  (rd_busy),
    .busy_map_o (busy_map)
  );

  // Hazard is judged on the held copy every cycle, so a freshly captured
  // instruction already sees the busy bit set by the one that issued with it.
  assign occupied = (state_q != EMPTY);
  assign hazard   = (reads_src(held_q.opcode) && (rd_busy[0] || rd_busy[1])) ||
                    ((reads_dest(held_q.opcode) || is_wr(held_q.opcode)) && rd_busy[2]);
  assign out_valid = occupied && !hazard && !flush;
  assign issue     = out_valid && out_ready;
  assign in_ready  = !flush && ((state_q == EMPTY) || issue);
  assign capture   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    held_d      = held_q;
    stall_cnt_d = stall_cnt_q;
    if (occupied && hazard && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush) begin
      state_d = EMPTY;
    end else if (capture) begin
      // Entered as HELD; becomes STALL next cycle if its hazard check fails.
      state_d = HELD;
      held_d  = '{opcode: opcode_in, dest: dest_in, s1: s1_in, s2: s2_in, imm: imm_in};
    end else if (issue) begin
      state_d = EMPTY;
    end else if (occupied) begin
      state_d = hazard ? STALL : HELD;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      held_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      held_q      <= held_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign opcode_out = held_q.opcode;
  assign dest_out   = held_q.dest;
  assign s1_out     = held_q.s1;
  assign s2_out     = held_q.s2;
  assign imm_out    = held_q.imm;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Self-checking bench for decode_issue_ctrl. Expected issued instructions
// are queued when driven; a negedge monitor pops and compares on every
// out_valid && out_ready. Directed checks cover reset, RAW stall, back-to-back
// issue, backpressure, set/clear collision, LDI/store, flush and mid-run reset.
module tb_decode_issue_ctrl;
  import pipe_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n, flush, in_valid, in_ready, out_valid, out_ready, wb_valid;
  logic [OP_W-1:0]   opcode_in, opcode_out;
  logic [RA_W-1:0]   dest_in, s1_in, s2_in, dest_out, s1_out, s2_out, wb_dest;
  logic [IMM_W-1:0]  imm_in, imm_out;
  logic [NREG-1:0]   busy_map;
  logic [SCNT_W-1:0] stall_cnt;

  int     checks = 0;
  int     failures = 0;
  int     exp_stall = 0;
  instr_t exp_q[$];

  always #5 clk = ~clk;

  decode_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode_in(opcode_in), .dest_in(dest_in), .s1_in(s1_in), .s2_in(s2_in), .imm_in(imm_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode_out(opcode_out), .dest_out(dest_out), .s1_out(s1_out), .s2_out(s2_out),
    .imm_out(imm_out),
    .wb_valid(wb_valid), .wb_dest(wb_dest),
    .busy_map(busy_map), .stall_cnt(stall_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic [4:0] op, input logic [3:0] d, a, b,
                                input logic [31:0] imm);
    return '{opcode: op, dest: d, s1: a, s2: b, imm: imm};
  endfunction

  task automatic drive(input instr_t x);
    in_valid  = 1'b1;
    opcode_in = x.opcode;
    dest_in   = x.dest;
    s1_in     = x.s1;
    s2_in     = x.s2;
    imm_in    = x.imm;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wb_cycle(input logic [3:0] r);
    wb_valid = 1'b1;
    wb_dest  = r;
    cyc();
    wb_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    instr_t got, want;
    if (rst_n && out_valid && out_ready) begin
      got = '{opcode: opcode_out, dest: dest_out, s1: s1_out, s2: s2_out, imm: imm_out};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL issue_unexpected: got %0h expected none", got);
      end else begin
        want = exp_q.pop_front();
        check("issue_payload", got, want);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    instr_t e_i, f_i;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode_in = '0; dest_in = '0; s1_in = '0; s2_in = '0; imm_in = '0;
    wb_valid = 1'b0; wb_dest = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy_map, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_out_regs", {opcode_out, dest_out, s1_out, s2_out, imm_out}, 0);

    // Back-to-back independent ALU ops.
    out_ready = 1'b1;
    drive(mk(5'b00001, 4'd1, 4'd0, 4'd0, 0)); exp_q.push_back(mk(5'b00001, 4'd1, 4'd0, 4'd0, 0));
    #1 check("b2b_in_ready", in_ready, 1); cyc();
    drive(mk(5'b00010, 4'd2, 4'd4, 4'd5, 0)); exp_q.push_back(mk(5'b00010, 4'd2, 4'd4, 4'd5, 0));
    #1 check("b2b_valid_1", out_valid, 1); cyc();
    drive(mk(5'b01000, 4'd6, 4'd7, 4'd8, 0)); exp_q.push_back(mk(5'b01000, 4'd6, 4'd7, 4'd8, 0));
    #1 check("b2b_valid_2", out_valid, 1); cyc();
    drive(mk(5'b00110, 4'd9, 4'd10, 4'd11, 0)); exp_q.push_back(mk(5'b00110, 4'd9, 4'd10, 4'd11, 0));
    #1 check("b2b_valid_3", out_valid, 1); cyc();
    idle();
    #1 check("b2b_valid_4", out_valid, 1); cyc();
    #1 check("b2b_drained", out_valid, 0);
    check("b2b_busy", busy_map, 16'h0246);
    wb_cycle(4'd1); wb_cycle(4'd2); wb_cycle(4'd6); wb_cycle(4'd9);
    #1 check("wb_clear_all", busy_map, 0);
    wb_cycle(4'd12);
    #1 check("wb_non_busy_ignored", busy_map, 0);

    // RAW: writer of r3 followed by reader of r3.
    drive(mk(5'b00001, 4'd3, 4'd0, 4'd0, 0)); exp_q.push_back(mk(5'b00001, 4'd3, 4'd0, 4'd0, 0));
    cyc();
    drive(mk(5'b00010, 4'd7, 4'd3, 4'd0, 0)); exp_q.push_back(mk(5'b00010, 4'd7, 4'd3, 4'd0, 0));
    #1 check("raw_writer_issue", out_valid, 1);
    check("raw_zero_bubble_ready", in_ready, 1); cyc();
    idle();
    #1 check("raw_stall_a", out_valid, 0);
    check("raw_busy3", busy_map, 16'h0008); cyc();
    #1 check("raw_stall_b", out_valid, 0);
    check("raw_stall_cnt_1", stall_cnt, exp_stall + 1); cyc();
    wb_valid = 1'b1; wb_dest = 4'd3;
    #1 check("raw_stall_cnt_2", stall_cnt, exp_stall + 2);
`ifdef ISSUE_BYPASS_EN
    check("raw_issue_same_cycle", out_valid, 1); cyc(); wb_valid = 1'b0;
    #1 check("raw_done", out_valid, 0);
    check("raw_stall_cnt_final", stall_cnt, exp_stall + 2);
    check("raw_busy7", busy_map, 16'h0080);
    exp_stall += 2;
`else
    check("raw_no_issue_wb_cycle", out_valid, 0); cyc(); wb_valid = 1'b0;
    #1 check("raw_issue_next_cycle", out_valid, 1);
    check("raw_stall_cnt_final", stall_cnt, exp_stall + 3);
    check("raw_busy_cleared", busy_map, 0);
    exp_stall += 3;
    cyc();
    #1 check("raw_done", out_valid, 0);
    check("raw_busy7", busy_map, 16'h0080);
`endif
    wb_cycle(4'd7);

    // Backpressure in HELD.
    out_ready = 1'b0;
    e_i = mk(5'b00011, 4'd4, 4'd1, 4'd2, 32'h1234);
    f_i = mk(5'b00100, 4'd5, 4'd1, 4'd2, 0);
    drive(e_i); exp_q.push_back(e_i); cyc();
    drive(f_i); exp_q.push_back(f_i);
    for (int k = 0; k < 3; k++) begin
      #1 check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold", {opcode_out, dest_out, s1_out, s2_out, imm_out}, e_i);
      check("bp_busy", busy_map, 0);
      cyc();
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", in_ready, 1); cyc();
    idle();
    #1 check("bp_next_valid", out_valid, 1);
    check("bp_next_op", opcode_out, 5'b00100);
    check("bp_busy4", busy_map, 16'h0010); cyc();
    #1 check("bp_drained", out_valid, 0);
    check("bp_busy45", busy_map, 16'h0030);

    // WAW on r5 with writeback of r5 landing on the issue cycle.
    drive(mk(5'b00101, 4'd5, 4'd0, 4'd0, 0)); exp_q.push_back(mk(5'b00101, 4'd5, 4'd0, 4'd0, 0));
    cyc();
    idle();
    #1 check("waw_stall", out_valid, 0); cyc();
    wb_valid = 1'b1; wb_dest = 4'd5;
`ifdef ISSUE_BYPASS_EN
    #1 check("coll_issue", out_valid, 1); cyc(); wb_valid = 1'b0;
    exp_stall += 1;
`else
    #1 check("coll_wait", out_valid, 0); cyc();
    #1 check("coll_issue", out_valid, 1); cyc(); wb_valid = 1'b0;
    exp_stall += 2;
`endif
    #1 check("coll_set_wins", busy_map, 16'h0030);
    check("coll_stall_cnt", stall_cnt, exp_stall);
    wb_cycle(4'd4); wb_cycle(4'd5);
    #1 check("coll_cleared", busy_map, 0);

    // LDI ignores busy sources; store waits on dest; flush drops it.
    drive(mk(5'b01001, 4'd8, 4'd0, 4'd0, 0)); exp_q.push_back(mk(5'b01001, 4'd8, 4'd0, 4'd0, 0));
    cyc();
    drive(mk(5'b11001, 4'd2, 4'd8, 4'd8, 32'hDEAD_BEEF));
    exp_q.push_back(mk(5'b11001, 4'd2, 4'd8, 4'd8, 32'hDEAD_BEEF));
    #1 check("ldi_pre_issue", out_valid, 1); cyc();
    drive(mk(5'b11011, 4'd2, 4'd0, 4'd0, 0));
    #1 check("ldi_issue", out_valid, 1);
    check("ldi_imm", imm_out, 32'hDEAD_BEEF);
    check("ldi_busy8", busy_map, 16'h0100); cyc();
    idle();
    #1 check("st_stall", out_valid, 0);
    check("st_busy", busy_map, 16'h0104); cyc();
    flush = 1'b1; wb_valid = 1'b1; wb_dest = 4'd8;
    #1 check("flush_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 0); cyc();
    flush = 1'b0; wb_valid = 1'b0;
    #1 check("flush_empty_valid", out_valid, 0);
    check("flush_empty_ready", in_ready, 1);
    check("flush_busy", busy_map, 16'h0004);
    exp_stall += 2;
    check("st_stall_cnt", stall_cnt, exp_stall);

    // Flush while HELD with execute ready: nothing issues.
    drive(mk(5'b00000, 4'd0, 4'd0, 4'd0, 0)); cyc();
    idle(); flush = 1'b1;
    #1 check("flush_held_valid", out_valid, 0);
    check("flush_held_ready", in_ready, 0); cyc();
    flush = 1'b0;
    #1 check("flush_held_empty", in_ready, 1);
    check("flush_held_no_valid", out_valid, 0);
    wb_cycle(4'd2);

    // Reset while stalled with r3 pending.
    drive(mk(5'b00001, 4'd3, 4'd0, 4'd0, 0)); exp_q.push_back(mk(5'b00001, 4'd3, 4'd0, 4'd0, 0));
    cyc();
    drive(mk(5'b00010, 4'd7, 4'd3, 4'd0, 0));
    #1 check("rst2_writer_issue", out_valid, 1); cyc();
    idle(); cyc();
    #1 check("rst2_stalled", out_valid, 0);
    check("rst2_busy", busy_map, 16'h0008);
    rst_n = 1'b0;
    #1 check("rst2_busy_clear", busy_map, 0);
    check("rst2_out_valid", out_valid, 0);
    check("rst2_in_ready", in_ready, 1);
    check("rst2_stall_cnt", stall_cnt, 0);
    check("rst2_out_regs", {opcode_out, dest_out, s1_out, s2_out, imm_out}, 0);
    cyc();
    rst_n = 1'b1;
    drive(mk(5'b00001, 4'd1, 4'd0, 4'd0, 0)); exp_q.push_back(mk(5'b00001, 4'd1, 4'd0, 4'd0, 0));
    cyc();
    idle();
    #1 check("post_rst_issue", out_valid, 1); cyc();
    #1 check("post_rst_busy", busy_map, 16'h0002);

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
